// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer for the 8-bit ALUSystem.
// Optional feature macro: CU_COND_BRANCH_EN enables BEQ/BNE and the shadow Zero flag;
// without it opcodes C/D execute as NOP and no shadow flag is kept.

module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  SeqState
);

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_LDAR = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_DEC  = 4'hA;
  localparam logic [3:0] OP_BRA  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_CLR     = 3'd0,
    S_FETCH_H = 3'd1,
    S_FETCH_L = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  state_t     cur;
  logic [3:0] op;
  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] rx_en;
  logic       branch;
  logic       unused_bits;

  assign op    = IROut[15:12];
  assign rx    = IROut[11:10];
  assign ry    = IROut[9:8];
  assign rx_en = ~(4'b0001 << rx);

`ifdef CU_COND_BRANCH_EN
  logic zshadow;
  logic zshadow_load;

  assign unused_bits = ^{IROut[7:0], ALUOutFlag[2:0]};

  // Shadow Zero flag: captures the ALU Z flag at the end of an ALU EXEC cycle
  always_ff @(posedge Clock) begin
    if (Reset)             zshadow <= 1'b0;
    else if (zshadow_load) zshadow <= ALUOutFlag[3];
  end
`else
  assign unused_bits = ^{IROut[7:0], ALUOutFlag};
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_CLR;
    else       state <= state_next;
  end

  // Next-state and control decode; Reset forces the CLR decode in the same cycle
  always_comb begin
    cur         = Reset ? S_CLR : state;
    state_next  = cur;
    RF_OutASel  = 2'b00;
    RF_OutBSel  = 2'b00;
    RF_FunSel   = 2'b00;
    RF_RegSel   = 4'b1111;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    Halted      = 1'b0;
    SeqState    = 3'(cur);
    branch      = 1'b0;
`ifdef CU_COND_BRANCH_EN
    zshadow_load = 1'b0;
`endif
    case (cur)
      S_CLR: begin
        RF_RegSel  = 4'b0000;
        RF_FunSel  = 2'b11;
        ARF_RegSel = 3'b000;
        ARF_FunSel = 2'b11;
        IR_Enable  = 1'b1;
        IR_Funsel  = 2'b11;
        state_next = S_FETCH_H;
      end
      S_FETCH_H, S_FETCH_L: begin
        ARF_OutDSel = 2'b00;
        Mem_CS      = 1'b0;
        IR_Enable   = 1'b1;
        IR_LH       = (cur == S_FETCH_L);
        IR_Funsel   = 2'b10;
        ARF_RegSel  = 3'b110;
        ARF_FunSel  = 2'b01;
        state_next  = (cur == S_FETCH_H) ? S_FETCH_L : S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH_H;
        case (op)
          OP_LDI: begin
            MuxASel   = 2'b00;
            RF_FunSel = 2'b10;
            RF_RegSel = rx_en;
          end
          OP_LDM: begin
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            MuxASel     = 2'b01;
            RF_FunSel   = 2'b10;
            RF_RegSel   = rx_en;
          end
          OP_STM: begin
            RF_OutASel  = rx;
            MuxCSel     = 1'b1;
            ALU_FunSel  = 4'b0000;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          OP_LDAR: begin
            MuxBSel    = 2'b01;
            ARF_RegSel = 3'b101;
            ARF_FunSel = 2'b10;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            RF_OutASel = rx;
            RF_OutBSel = ry;
            MuxCSel    = 1'b1;
            MuxASel    = 2'b11;
            RF_FunSel  = 2'b10;
            RF_RegSel  = rx_en;
            case (op)
              OP_ADD:  ALU_FunSel = 4'b0100;
              OP_SUB:  ALU_FunSel = 4'b0110;
              OP_AND:  ALU_FunSel = 4'b0111;
              OP_OR:   ALU_FunSel = 4'b1000;
              default: ALU_FunSel = 4'b1001;
            endcase
`ifdef CU_COND_BRANCH_EN
            zshadow_load = 1'b1;
`endif
          end
          OP_INC: begin
            RF_RegSel = rx_en;
            RF_FunSel = 2'b01;
          end
          OP_DEC: begin
            RF_RegSel = rx_en;
            RF_FunSel = 2'b00;
          end
          OP_BRA: branch = 1'b1;
`ifdef CU_COND_BRANCH_EN
          OP_BEQ: branch = zshadow;
          OP_BNE: branch = ~zshadow;
`endif
          OP_HLT: state_next = S_HALT;
          default: ;
        endcase
        if (branch) begin
          MuxBSel    = 2'b01;
          ARF_RegSel = 3'b110;
          ARF_FunSel = 2'b10;
        end
      end
      S_HALT: Halted = 1'b1;
      default: state_next = S_CLR;
    endcase
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired fetch/decode/execute sequencer for the 8-bit ALUSystem datapath. It fetches 16-bit instructions from Memory at PC into IR in two byte cycles, decodes IR, and drives every ALUSystem control input for one execute cycle per instruction. It also keeps a shadow Zero flag for conditional branches. It sits beside ALUSystem; the top level connects IROut and ALUOutFlag back into it.

## Interface
- No parameters; datapath width fixed at 8 bits, instruction width 16 bits.
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- IROut  in  16  IR contents.
- ALUOutFlag  in  4  {Z,C,N,O} from ALU.
- RF_OutASel, RF_OutBSel, RF_FunSel  out  2 each  RegFile controls.
- RF_RegSel  out  4  active-low register enables (R1..R4 = bit0..3).
- ALU_FunSel  out  4  ALU operation.
- ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out  2 each  ARF controls; OutD addresses Memory.
- ARF_RegSel  out  3  active-low enables {SP,AR,PC}.
- IR_LH, IR_Enable  out  1 each  IR half select (0 = [15:8]) and enable; IR_Funsel  out  2.
- Mem_WR, Mem_CS  out  1 each  write=1, chip select active-low.
- MuxASel, MuxBSel  out  2 each; MuxCSel  out  1.
- Halted  out  1  high in HALT state.
- SeqState  out  3  current state encoding (debug).

## Operation
- States: CLR(0), FETCH_H(1), FETCH_L(2), EXEC(3), HALT(4). Outputs are decoded combinationally from state and IROut.
- Idle defaults in every state unless overridden: RF_RegSel=1111, ARF_RegSel=111, IR_Enable=0, Mem_CS=1, Mem_WR=0, all selects/FunSels 0.
- CLR: RF_RegSel=0000, RF_FunSel=11; ARF_RegSel=000, ARF_FunSel=11; IR_Enable=1, IR_Funsel=11. Next state FETCH_H.
- FETCH_H: ARF_OutDSel=00, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=10; ARF_RegSel=110, ARF_FunSel=01 (PC+1). Next FETCH_L.
- FETCH_L: same with IR_LH=1. Next EXEC.
- Decode fields: op=IR[15:12]; Rx=IR[11:10]; Ry=IR[9:8]; imm=IR[7:0]. Rx enable = active-low one-hot of Rx.
- 0 LDI: MuxASel=00, RF_FunSel=10, enable Rx.
- 1 LDM: ARF_OutDSel=10, Mem_CS=0, MuxASel=01, RF_FunSel=10, enable Rx.
- 2 STM: RF_OutASel=Rx, MuxCSel=1, ALU_FunSel=0000, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
- 3 LDAR: MuxBSel=01, ARF_RegSel=101, ARF_FunSel=10.
- 4 ADD/5 SUB/6 AND/7 OR/8 XOR: RF_OutASel=Rx, RF_OutBSel=Ry, MuxCSel=1, ALU_FunSel=0100/0110/0111/1000/1001, MuxASel=11, RF_FunSel=10, enable Rx; Zshadow←ALUOutFlag[3] at the closing posedge.
- 9 INC/A DEC: enable Rx, RF_FunSel=01/00; Zshadow unchanged.
- B BRA: MuxBSel=01, ARF_RegSel=110, ARF_FunSel=10.
- C BEQ/D BNE: as BRA only if Zshadow=1 / Zshadow=0, otherwise idle.
- E NOP: idle. F HLT: idle, next HALT.
- EXEC next state FETCH_H, except HLT.
- HALT: idle outputs; stays until Reset.

## Timing
- Every instruction takes 3 cycles: FETCH_H, FETCH_L, EXEC. HLT takes 3 cycles, then HALT.
- PC advances by 2 during fetch. A taken branch loads imm at the EXEC posedge; the next FETCH_H uses the new PC.
- The ALU computes flags at negedge; Zshadow samples them at the following posedge, which ends the ALU EXEC cycle.
- Reset=1 forces all outputs to CLR values combinationally; no memory write or IR load escapes in that cycle.
- Reset=1 at a posedge: state←CLR, Zshadow←0. First FETCH_H is one cycle after CLR.
- Reset held high for N cycles keeps the block in CLR; clears repeat harmlessly.
- Reset-time outputs: CLR values; Halted=0, SeqState=0.
- Undefined encodings do not exist: all 16 opcodes are decoded.

## Configuration
- CU_COND_BRANCH_EN defined: BEQ/BNE behave as above, and the Zshadow register exists.
- Not defined: opcodes C and D execute as NOP, and Zshadow is removed.

## Test plan
- Reset high 2 cycles, then low → CLR then FETCH_H; ARF_OutDSel=00, Mem_CS=0, IR_LH=0; PC=0x00.
- M[0..1]=0x04,0x5A (LDI R2,0x5A) → in EXEC, MuxASel=00, RF_RegSel=1101, RF_FunSel=10; R2=0x5A, PC=0x02.
- R1=0x7F, R2=0x7F, SUB R1,R2 (0x5100) then BEQ 0x40 (0xC040) → R1=0x00, Zshadow=1, PC=0x40 after the BEQ EXEC.
- LDAR 0x80 then STM R3 with R3=0x33 → M[0x80]=0x33; Mem_WR high exactly one cycle.
- Reset asserted in the STM EXEC cycle → Mem_WR=0 in that cycle, M[0x80] unchanged, next state CLR.
- HLT (0xF000) → Halted=1 and PC frozen for 10 cycles. Build without CU_COND_BRANCH_EN: BEQ with zero result → PC simply +2.
